dmac_job_sched: RTL
===================

DMAC_JOB_SCHED -- requirements
Module: dmac_job_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, engine watchdog limit in clk cycles (used only when DMAC_SCHED_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  2  per-requester job request, bit n = requester n.
REQ-005 SHALL have port req_ready_o  output  2  per-requester job accept, at most one bit high per cycle.
REQ-006 SHALL have ports req0_src_i / req1_src_i  input  32 each  source matrix byte address.
REQ-007 SHALL have ports req0_dst_i / req1_dst_i  input  32 each  destination (padded) matrix byte address.
REQ-008 SHALL have ports req0_width_i / req1_width_i  input  6 each  source matrix width N (N x N).
REQ-009 SHALL have ports eng_src_o / eng_dst_o  output  32 each, and eng_width_o  output  6: job configuration driven to the padding engine.
REQ-010 SHALL have port eng_start_o  output  1  engine start pulse.
REQ-011 SHALL have port eng_done_i  input  1  engine idle/done level (high when idle, low while busy).
REQ-012 SHALL have ports cmpl_valid_o  output  1, cmpl_port_o  output  1 (requester index) and cmpl_err_o  output  1 (job rejected or failed).
REQ-013 SHALL have port busy_o  output  1  high in every state except S_IDLE.

Function
REQ-014 SHALL implement states S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_REPORT and S_HALT.
REQ-015 In S_IDLE with any req_valid_i bit set and eng_done_i high, SHALL assert req_ready_o for the winning requester in that same cycle (combinational), capture its src/dst/width and port index, and move to S_ISSUE.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; if only one is valid, it wins; the last-grant pointer updates only on accept.
REQ-017 A captured width of 0 or not a multiple of 4 SHALL skip the engine: S_ISSUE goes directly to S_REPORT with cmpl_err_o=1.
REQ-018 In S_ISSUE with a valid width, SHALL drive eng_start_o=1 for exactly one cycle and move to S_WAIT_BUSY; eng_src/dst/width_o SHALL hold the captured values from S_ISSUE until the next accept.
REQ-019 In S_WAIT_BUSY, SHALL ignore eng_done_i high and move to S_WAIT_DONE on the first cycle eng_done_i is low.
REQ-020 In S_WAIT_DONE, SHALL move to S_REPORT on the first cycle eng_done_i is high, with cmpl_err_o=0.
REQ-021 In S_REPORT, SHALL assert cmpl_valid_o for exactly one cycle with cmpl_port_o equal to the captured port index, then return to S_IDLE.
REQ-022 SHALL issue no new job while a job is outstanding; req_ready_o SHALL be 0 in all states except S_IDLE.
REQ-023 A request arriving in the same cycle as cmpl_valid_o SHALL NOT be accepted before the following cycle, when the FSM is back in S_IDLE.
REQ-024 SHALL hold a requester's deasserted req_valid_i as no request; it places no obligation to retain requests that are withdrawn.

Reset
REQ-025 On rst_n low at a clock edge, SHALL enter S_IDLE and set the last-grant pointer to requester 1, so requester 0 wins first.
REQ-026 Reset values: req_ready_o=0, eng_start_o=0, eng_src_o=0, eng_dst_o=0, eng_width_o=0, cmpl_valid_o=0, cmpl_port_o=0, cmpl_err_o=0, busy_o=0.
REQ-027 Reset mid-job SHALL abandon the job with no completion report; the engine is reset by the same rst_n.

Configuration
REQ-028 With macro DMAC_SCHED_TIMEOUT_EN defined, SHALL count cycles spent in S_WAIT_BUSY plus S_WAIT_DONE; when the count reaches TIMEOUT_CYCLES, SHALL pulse cmpl_valid_o with cmpl_err_o=1 and enter S_HALT.
REQ-029 S_HALT SHALL keep req_ready_o=0 and busy_o=1 until reset.
REQ-030 Without DMAC_SCHED_TIMEOUT_EN, SHALL contain no watchdog counter and no S_HALT entry path; a waiting job waits indefinitely.

Verification
REQ-031 Requester 0 submits a valid job (src=0x1000, dst=0x2000, width=8); engine model lowers done 1 cycle after start and raises it 20 cycles later -> one eng_start_o pulse with the job values, then cmpl_valid_o=1, cmpl_port_o=0, cmpl_err_o=0.
REQ-032 Both requesters hold valid for 4 jobs -> accept order 0,1,0,1, and each completion precedes the next accept.
REQ-033 Requester 1 submits width=6 -> no eng_start_o pulse; cmpl_valid_o=1, cmpl_port_o=1, cmpl_err_o=1 two cycles after accept.
REQ-034 rst_n is asserted while in S_WAIT_DONE -> all outputs equal their reset values on the next cycle, and no completion is reported.
REQ-035 With DMAC_SCHED_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, the engine never raises done -> error completion on wait cycle 16, then req_ready_o stays 0 until reset.

Source files
------------

// File: rtl/dmac_job_sched_if.sv
// dmac_job_sched_if: requester, engine and completion signals of the DMA job scheduler.
// Ports: none; the sched modport is the scheduler side, the tb modport drives requesters and the engine.
interface dmac_job_sched_if;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [31:0] req0_src_i;
    logic [31:0] req1_src_i;
    logic [31:0] req0_dst_i;
    logic [31:0] req1_dst_i;
    logic [5:0]  req0_width_i;
    logic [5:0]  req1_width_i;
    logic [31:0] eng_src_o;
    logic [31:0] eng_dst_o;
    logic [5:0]  eng_width_o;
    logic        eng_start_o;
    logic        eng_done_i;
    logic        cmpl_valid_o;
    logic        cmpl_port_o;
    logic        cmpl_err_o;
    logic        busy_o;
    modport sched (
        input  req_valid_i, req0_src_i, req1_src_i, req0_dst_i, req1_dst_i,
               req0_width_i, req1_width_i, eng_done_i,
        output req_ready_o, eng_src_o, eng_dst_o, eng_width_o, eng_start_o,
               cmpl_valid_o, cmpl_port_o, cmpl_err_o, busy_o
    );
    modport tb (
        output req_valid_i, req0_src_i, req1_src_i, req0_dst_i, req1_dst_i,
               req0_width_i, req1_width_i, eng_done_i,
        input  req_ready_o, eng_src_o, eng_dst_o, eng_width_o, eng_start_o,
               cmpl_valid_o, cmpl_port_o, cmpl_err_o, busy_o
    );
endinterface

// File: rtl/dmac_job_sched.sv
// dmac_job_sched: round-robin scheduler of two requesters onto one matrix padding engine.
// Ports: clk, rst_n (sync, active-low); bus (dmac_job_sched_if.sched) carries requests,
// engine config/start/done, completion report and busy.
// Optional watchdog: define DMAC_SCHED_TIMEOUT_EN to abort a stuck job after TIMEOUT_CYCLES.
module dmac_job_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic              clk,
    input logic              rst_n,
    dmac_job_sched_if.sched  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_REPORT, S_HALT} state_t;
    state_t      r_state;
    logic        r_last;
    logic        r_port;
    logic        r_bad;
    logic        r_start;
    logic        r_cv;
    logic        r_err;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [5:0]  r_width;
    logic        w_acc;
    logic        w_gnt;
    logic        w_bad;
    logic [5:0]  w_width;
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end
    // With both requesting, the one not granted last wins.
    assign w_gnt   = &bus.req_valid_i ? ~r_last : bus.req_valid_i[1];
    assign w_acc   = r_state == S_IDLE && |bus.req_valid_i && bus.eng_done_i;
    assign w_width = w_gnt ? bus.req1_width_i : bus.req0_width_i;
    assign w_bad   = w_width == 6'd0 || w_width[1:0] != 2'b00;
    assign bus.req_ready_o  = w_acc ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign bus.eng_src_o    = r_src;
    assign bus.eng_dst_o    = r_dst;
    assign bus.eng_width_o  = r_width;
    assign bus.eng_start_o  = r_start;
    assign bus.cmpl_valid_o = r_cv;
    assign bus.cmpl_port_o  = r_port;
    assign bus.cmpl_err_o   = r_err;
    assign bus.busy_o       = r_state != S_IDLE;
`ifdef DMAC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    logic          w_wait;
    logic          w_tmo;
    assign w_wait = r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE;
    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign w_tmo  = w_wait && r_cnt + CW'(1) == TMO;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_bad   <= 1'b0;
            r_start <= 1'b0;
            r_cv    <= 1'b0;
            r_err   <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_width <= '0;
        end else begin
            r_start <= 1'b0;
            r_cv    <= 1'b0;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_state <= S_ISSUE;
                    r_last  <= w_gnt;
                    r_port  <= w_gnt;
                    r_src   <= w_gnt ? bus.req1_src_i : bus.req0_src_i;
                    r_dst   <= w_gnt ? bus.req1_dst_i : bus.req0_dst_i;
                    r_width <= w_width;
                    r_bad   <= w_bad;
                    // Start is registered here so it is high exactly during S_ISSUE.
                    r_start <= !w_bad;
                end
                S_ISSUE: begin
                    r_state <= r_bad ? S_REPORT : S_WAIT_BUSY;
                    r_cv    <= r_bad;
                    r_err   <= r_bad;
                end
                S_WAIT_BUSY: if (!bus.eng_done_i) r_state <= S_WAIT_DONE;
                S_WAIT_DONE: if (bus.eng_done_i) begin
                    r_state <= S_REPORT;
                    r_cv    <= 1'b1;
                    r_err   <= 1'b0;
                end
                S_REPORT: r_state <= S_IDLE;
                default: r_state <= r_state;
            endcase
`ifdef DMAC_SCHED_TIMEOUT_EN
            if (w_tmo) begin
                r_state <= S_HALT;
                r_cv    <= 1'b1;
                r_err   <= 1'b1;
            end
`endif
        end
    end
`ifdef DMAC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= w_wait ? r_cnt + CW'(1) : '0;
    end
`endif
endmodule
